// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core: one shared memory port and a six-state FSM
// (FETCH, DECODE, EXEC, MEM, WB, HALT). Supports add/sub/and/or/slt, addi,
// lw, sw, beq and j. Any other opcode or funct halts the core until reset.
module mips_multicycle_core #(
  parameter int ADDR_W = 32,
  parameter int NREG = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [31:0]       instret,
  output logic [2:0]        state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  logic [31:0]       ir, a, b, imm_sx, aluout, mdr;
  logic [ADDR_W-1:0] target;
  logic [31:0]       gpr [NREG];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sx, br_off, pc32, jt32;
  logic [31:0] ra, rb, alu_res, wb_data;
  logic [4:0]  wb_idx;
  logic        legal;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign sx     = {{16{ir[15]}}, ir[15:0]};
  assign br_off = {sx[29:0], 2'b00};
  // Jump keeps the top PC nibble; for narrow address spaces the nibble is
  // zero and the result is simply truncated.
  assign pc32   = 32'(pc);
  assign jt32   = {pc32[31:28], ir[25:0], 2'b00};

  assign halted  = (state == S_HALT);
  assign wb_idx  = (op == OP_RTYPE) ? rd : rt;
  assign wb_data = (op == OP_LW) ? mdr : aluout;

  // Decode legality: unknown opcode or R-type funct sends the core to HALT.
  always_comb begin
    case (op)
      OP_RTYPE: legal = (funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT});
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Register-file read; R0 and unimplemented indices read as zero.
  always_comb begin
    ra = '0;
    rb = '0;
    for (int i = 1; i < NREG; i++) begin
      if (rs == 5'(i)) ra = gpr[i];
      if (rt == 5'(i)) rb = gpr[i];
    end
  end

  // ALU: R-type ops on A/B, everything else is A + sign-extended immediate.
  always_comb begin
    alu_res = a + imm_sx;
    if (op == OP_RTYPE) begin
      case (funct)
        F_SUB:   alu_res = a - b;
        F_AND:   alu_res = a & b;
        F_OR:    alu_res = a | b;
        F_SLT:   alu_res = {31'd0, $signed(a) < $signed(b)};
        default: alu_res = a + b;
      endcase
    end
  end

  // Memory port: active only in FETCH and MEM, forced idle while reset is sampled.
  always_comb begin
    mem_req   = !rst && (state == S_FETCH || state == S_MEM);
    mem_we    = !rst && (state == S_MEM) && (op == OP_SW);
    mem_addr  = (state == S_MEM) ? aluout[ADDR_W-1:0] : pc;
    mem_wdata = b;
  end

  // Main FSM and architectural state; reset overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      instret <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm_sx  <= '0;
      aluout  <= '0;
      mdr     <= '0;
      target  <= '0;
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_W'(4);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a      <= ra;
          b      <= rb;
          imm_sx <= sx;
          target <= pc + br_off[ADDR_W-1:0];
          state  <= legal ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          case (op)
            OP_BEQ: begin
              if (a == b) pc <= target;
              instret <= instret + 32'd1;
              state   <= S_FETCH;
            end
            OP_J: begin
              pc      <= jt32[ADDR_W-1:0];
              instret <= instret + 32'd1;
              state   <= S_FETCH;
            end
            OP_LW, OP_SW: begin
              aluout <= alu_res;
              state  <= S_MEM;
            end
            default: begin
              aluout <= alu_res;
              state  <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op == OP_SW) begin
              instret <= instret + 32'd1;
              state   <= S_FETCH;
            end else begin
              mdr   <= mem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          for (int i = 1; i < NREG; i++)
            if (wb_idx == 5'(i)) gpr[i] <= wb_data;
          instret <= instret + 32'd1;
          state   <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed scenarios plus random forward-only
// programs compared against an instruction-level reference model.
module tb_mips_multicycle_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // main DUT (defaults) and its memory
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, instret;
  logic [2:0]  state;
  logic [31:0] mem [256];

  mips_multicycle_core dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .halted(halted), .instret(instret),
    .state(state)
  );

  // small-register-file DUT with nonzero reset PC, zero-wait memory
  logic        req1, we1, ready1, halted1;
  logic [31:0] addr1, wdata1, rdata1, pc1, instret1;
  logic [2:0]  state1;
  logic [31:0] mem1 [256];

  mips_multicycle_core #(.ADDR_W(32), .NREG(8), .RESET_PC(32'h100)) dut1 (
    .clk(clk), .rst(rst), .mem_req(req1), .mem_we(we1),
    .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1),
    .mem_ready(ready1), .pc(pc1), .halted(halted1), .instret(instret1),
    .state(state1)
  );

  // memory model with configurable wait states
  int fetch_wait = 0, data_wait = 0, rnd_w = 0, wcnt = 0, wtgt;
  bit rand_wait = 0;
  int store_cnt = 0, we_cyc = 0, we_ok = 0;

  always_comb wtgt = rand_wait ? rnd_w : ((state == 3'd3) ? data_wait : fetch_wait);
  assign mem_ready = mem_req && (wcnt >= wtgt);
  assign mem_rdata = mem[mem_addr[9:2]];
  assign ready1    = req1;
  assign rdata1    = mem1[addr1[9:2]];

  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[9:2]] = mem_wdata;
      store_cnt = store_cnt + 1;
    end
    if (req1 && we1) mem1[addr1[9:2]] = wdata1;
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_ready) rnd_w <= $urandom_range(0, 2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // handshake monitors: hold stability and idle-port rule
  logic        pend = 1'b0, p_we;
  logic [31:0] p_addr, p_wdata;
  always @(negedge clk) begin
    if (!rst) begin
      if (pend) begin
        chk("hold_req", {31'd0, mem_req}, 32'd1);
        chk("hold_addr", mem_addr, p_addr);
        chk("hold_wdata", mem_wdata, p_wdata);
        chk("hold_we", {31'd0, mem_we}, {31'd0, p_we});
      end
      if (state != 3'd0 && state != 3'd3)
        chk("idle_port", {30'd0, mem_req, mem_we}, 32'd0);
      if (mem_req && mem_we) begin
        we_cyc++;
        if (mem_addr == 32'h40 && mem_wdata == 32'd12) we_ok++;
      end
    end
    pend    = !rst && mem_req && !mem_ready;
    p_addr  = mem_addr;
    p_wdata = mem_wdata;
    p_we    = mem_we;
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_j(input logic [25:0] idx);
    return {6'h02, idx};
  endfunction

  task automatic load_prep();
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, input string tag);
    bit ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (halted) begin ok = 1; break; end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  // reference model state
  logic [31:0] im [256];
  logic [31:0] rr [32];
  logic [31:0] ipc;
  int          icnt;

  task automatic ref_run();
    logic [31:0] ins, va, vb, sxv, ea, res;
    logic [4:0]  rs, rt, rd;
    bit stop = 0;
    for (int i = 0; i < 32; i++) rr[i] = 0;
    ipc = 0;
    icnt = 0;
    for (int step = 0; step < 1000 && !stop; step++) begin
      ins = im[ipc[9:2]];
      ipc = ipc + 4;
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      va = rr[rs]; vb = rr[rt];
      sxv = {{16{ins[15]}}, ins[15:0]};
      ea = va + sxv;
      case (ins[31:26])
        6'h00: begin
          case (ins[5:0])
            6'h20: res = va + vb;
            6'h22: res = va - vb;
            6'h24: res = va & vb;
            6'h25: res = va | vb;
            6'h2A: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
            default: begin res = 0; stop = 1; end
          endcase
          if (!stop) begin
            if (rd != 0) rr[rd] = res;
            icnt++;
          end
        end
        6'h08: begin if (rt != 0) rr[rt] = ea; icnt++; end
        6'h23: begin if (rt != 0) rr[rt] = im[ea[9:2]]; icnt++; end
        6'h2B: begin im[ea[9:2]] = vb; icnt++; end
        6'h04: begin if (va == vb) ipc = ipc + (sxv << 2); icnt++; end
        6'h02: begin ipc = {ipc[31:28], ins[25:0], 2'b00}; icnt++; end
        default: stop = 1;
      endcase
    end
  endtask

  initial begin
    int n, k, nreq, last;
    int t_ret[$];
    bit ok;
    logic [5:0] fn;

    // ---- reset state, straight-line arithmetic (zero wait) ----
    for (int i = 0; i < 256; i++) begin mem[i] = '0; mem1[i] = '0; end
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    mem[3] = 32'hFC00_0000;
    mem1[64] = enc_i(6'h08, 5'd0, 5'd9, 16'd1);
    mem1[65] = enc_r(5'd9, 5'd0, 5'd2, 6'h20);
    mem1[66] = enc_i(6'h08, 5'd0, 5'd0, 16'd3);
    mem1[67] = enc_i(6'h08, 5'd0, 5'd7, 16'hFFFE);
    mem1[68] = 32'hFC00_0000;
    @(posedge clk); #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_req_low", {31'd0, mem_req}, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_req", {31'd0, mem_req}, 32'd1);
    chk("first_addr", mem_addr, 32'd0);
    chk("first_addr_rpc", addr1, 32'h100);
    repeat (12) @(posedge clk);
    #1;
    chk("add_r3", dut.gpr[3], 32'd12);
    chk("add_instret", instret, 32'd3);
    chk("add_pc", pc, 32'd12);
    chk("add_state", {29'd0, state}, 32'd0);

    // ---- small register file ----
    ok = 0;
    for (int c = 0; c < 60; c++) begin
      if (halted1) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("nreg_halt", {31'd0, ok}, 32'd1);
    chk("nreg_r2", dut1.gpr[2], 32'd0);
    chk("nreg_r0", dut1.gpr[0], 32'd0);
    chk("nreg_r7", dut1.gpr[7], 32'hFFFF_FFFE);
    chk("nreg_pc", pc1, 32'h114);
    chk("nreg_instret", instret1, 32'd4);

    // ---- illegal opcode at 0x8 ----
    load_prep();
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    mem[2] = 32'hFC00_0000;
    do_reset();
    run_to_halt(40, "ill_reach");
    chk("ill_state", {29'd0, state}, 32'd5);
    chk("ill_pc", pc, 32'hC);
    chk("ill_instret", instret, 32'd2);
    nreq = 0;
    for (int c = 0; c < 10; c++) begin @(negedge clk); nreq += int'(mem_req); end
    chk("ill_no_req", nreq, 32'd0);
    chk("ill_instret_hold", instret, 32'd2);
    chk("ill_still_halted", {31'd0, halted}, 32'd1);
    do_reset();
    chk("ill_rst_pc", pc, 32'd0);
    chk("ill_rst_halted", {31'd0, halted}, 32'd0);

    // ---- sw/lw with two data wait states ----
    load_prep();
    mem[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd12);
    mem[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'h40);
    mem[2] = enc_i(6'h23, 5'd0, 5'd4, 16'h40);
    mem[3] = 32'hFC00_0000;
    data_wait = 2;
    we_cyc = 0;
    we_ok = 0;
    do_reset();
    last = 0;
    for (int c = 0; c < 60 && !halted; c++) begin
      @(posedge clk); #1;
      if (int'(instret) != last) begin t_ret.push_back(c); last = int'(instret); end
    end
    chk("ls_retires", t_ret.size(), 32'd3);
    if (t_ret.size() == 3) begin
      chk("ls_sw_lat", t_ret[1] - t_ret[0], 32'd6);
      chk("ls_lw_lat", t_ret[2] - t_ret[1], 32'd7);
    end
    chk("ls_we_cycles", we_cyc, 32'd3);
    chk("ls_we_hold", we_ok, 32'd3);
    chk("ls_mem40", mem[16], 32'd12);
    chk("ls_r4", dut.gpr[4], 32'd12);
    data_wait = 0;

    // ---- j into a one-instruction beq loop at 0x10 ----
    load_prep();
    mem[0] = enc_j(26'd4);
    mem[4] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    do_reset();
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (state == 3'd0 && pc == 32'h10) begin ok = 1; break; end
    end
    chk("loop_enter", {31'd0, ok}, 32'd1);
    chk("loop_j_instret", instret, 32'd1);
    for (int it = 1; it <= 4; it++) begin
      repeat (3) @(posedge clk);
      #1;
      chk("loop_pc", pc, 32'h10);
      chk("loop_state", {29'd0, state}, 32'd0);
      chk("loop_instret", instret, 32'(1 + it));
    end

    // ---- reset during a stalled store ----
    load_prep();
    mem[0] = enc_i(6'h08, 5'd0, 5'd3, 16'd12);
    mem[1] = enc_i(6'h2B, 5'd0, 5'd3, 16'h40);
    mem[16] = 32'h5A5A_5A5A;
    data_wait = 50;
    do_reset();
    store_cnt = 0;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (state == 3'd3) begin ok = 1; break; end
    end
    chk("abort_reach_mem", {31'd0, ok}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("abort_req_low", {31'd0, mem_req}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_instret", instret, 32'd0);
    chk("abort_fetch_addr", mem_addr, 32'd0);
    chk("abort_fetch_req", {31'd0, mem_req}, 32'd1);
    chk("abort_no_store", store_cnt, 32'd0);
    chk("abort_mem40", mem[16], 32'h5A5A_5A5A);
    data_wait = 0;

    // ---- random forward-only programs with random wait states ----
    rand_wait = 1;
    for (int t = 0; t < 8; t++) begin
      load_prep();
      for (int i = 128; i < 256; i++) mem[i] = $urandom;
      n = $urandom_range(8, 30);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2: mem[i] = enc_i(6'h08, 5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)),
                                  16'($urandom));
          3, 4, 5: begin
            case ($urandom_range(0, 4))
              0: fn = 6'h20;
              1: fn = 6'h22;
              2: fn = 6'h24;
              3: fn = 6'h25;
              default: fn = 6'h2A;
            endcase
            mem[i] = enc_r(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                           5'($urandom_range(0, 31)), fn);
          end
          6: mem[i] = enc_i(6'h2B, 5'd0, 5'($urandom_range(0, 31)),
                            16'(32'h200 + 4 * $urandom_range(0, 127)));
          7: mem[i] = enc_i(6'h23, 5'd0, 5'($urandom_range(0, 31)),
                            16'(32'h200 + 4 * $urandom_range(0, 127)));
          8: begin
            k = $urandom_range(0, (n - i - 1 > 3) ? 3 : n - i - 1);
            mem[i] = enc_i(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'(k));
          end
          default: mem[i] = enc_j(26'($urandom_range(i + 1, n)));
        endcase
      end
      mem[n] = $urandom_range(0, 1) ? enc_r(5'd1, 5'd2, 5'd3, 6'h21)
                                    : {6'($urandom_range(0, 1) ? 6'h3F : 6'h0F), 26'd0};
      for (int i = 0; i < 256; i++) im[i] = mem[i];
      ref_run();
      do_reset();
      run_to_halt(3000, "rnd_halt");
      chk("rnd_pc", pc, ipc);
      chk("rnd_instret", instret, icnt);
      for (int r = 1; r < 32; r++) chk("rnd_gpr", dut.gpr[r], rr[r]);
      for (int i = 128; i < 256; i++) chk("rnd_mem", mem[i], im[i]);
    end
    rand_wait = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameter ADDR_W, default 32, memory byte-address width; legal range 8..32.
REQ-002 Parameter NREG, default 32, number of implemented GPRs; legal values 8, 16, 32.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
REQ-005 Port list (name, direction, width, meaning):
- `clk` in 1 -- clock; all state changes on its rising edge.
- `rst` in 1 -- synchronous active-high reset.
- `mem_req` out 1 -- memory request valid.
- `mem_we` out 1 -- 1 = store, 0 = load/fetch.
- `mem_addr` out ADDR_W -- byte address.
- `mem_wdata` out 32 -- store data.
- `mem_rdata` in 32 -- read data; valid only when `mem_ready`=1.
- `mem_ready` in 1 -- request completes this cycle.
- `pc` out ADDR_W -- current PC.
- `halted` out 1 -- core stopped on an illegal opcode.
- `instret` out 32 -- retired-instruction count.
- `state` out 3 -- FSM state, for debug.

Function
REQ-006 FSM states and `state` encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-007 FETCH behaviour:
- Drive `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`.
- Hold these outputs until a cycle with `mem_ready`=1.
- In that cycle: latch IR=`mem_rdata`, set `pc`=`pc`+4 (mod 2^ADDR_W), go to DECODE.
REQ-008 DECODE (one cycle):
- Latch A=R[rs], B=R[rt].
- Latch the sign-extended imm16.
- Compute branch target = `pc` + (sext(imm16)<<2).
- Go to EXEC.
REQ-009 Supported opcodes:
- R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
- addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- Any other opcode or funct: go to HALT; no register or memory write.
REQ-010 EXEC actions per instruction class:
- R-type / addi: ALUOut = A op B (or A + sext imm); go to WB.
- lw / sw: ALUOut = A + sext imm; go to MEM.
- beq: if A==B then `pc` = target; retire; go to FETCH.
- j: `pc` = {`pc`[ADDR_W-1:28], imm26, 2'b00}, truncated to ADDR_W; retire; go to FETCH.
REQ-011 Arithmetic rules:
- add/addi/sub wrap mod 2^32; no overflow trap.
- slt is a signed compare; result is 1 or 0.
REQ-012 MEM behaviour:
- Drive `mem_req`=1, `mem_addr`=ALUOut[ADDR_W-1:0], `mem_we`=1 for sw, `mem_wdata`=B.
- Hold all of these until `mem_ready`=1.
- sw: retire on the ready cycle, go to FETCH.
- lw: latch MDR=`mem_rdata`, go to WB.
REQ-013 WB (one cycle):
- Write R[rd] for R-type, R[rt] for addi/lw.
- Retire; go to FETCH.
REQ-014 Register-file rules:
- R[0] always reads 0; writes to index 0 are ignored.
- Indices >= NREG read 0; writes to them are ignored.
REQ-015 Outside FETCH and MEM, `mem_req`=0 and `mem_we`=0.
REQ-016 Memory handshake rules:
- Address and data are stable from assertion of `mem_req` until the `mem_ready` cycle.
- `mem_ready` while `mem_req`=0 is ignored.
REQ-017 Retire means `instret` increments by 1, wrapping at 2^32.
REQ-018 Latency with `mem_ready` tied high: beq and j 3 cycles; R-type, addi, sw 4 cycles; lw 5 cycles. Each wait cycle adds 1.
REQ-019 HALT behaviour:
- HALT is absorbing; only `rst` exits it.
- `halted`=1 only in HALT.
- `pc` holds the address after the illegal instruction.
REQ-020 Misaligned addresses: the low two address bits are driven as computed; the core performs no alignment check.

Reset
REQ-021 A rising edge of `clk` with `rst`=1 sets:
- `state`=FETCH, `pc`=RESET_PC, `instret`=0, `halted`=0.
- All GPRs, IR, A, B, ALUOut and MDR to 0.
REQ-022 Reset mid-operation:
- `rst` takes priority in every state, including a pending MEM.
- `mem_req`=0 in the cycle `rst` is sampled.
- The aborted store is not retired.
REQ-023 In the first cycle after reset deasserts, `mem_req`=1 and `mem_addr`=RESET_PC.

Verification
REQ-024 Scenario: program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 with zero-wait memory -> R3=12, `instret`=3 after 12 cycles, `pc`=12.
REQ-025 Scenario: sw $3,0x40($0) then lw $4,0x40($0) with `mem_ready` delayed 2 cycles per request -> `mem_addr`/`mem_wdata`=0x40/12 held for 3 cycles; R4=12; lw takes 7 cycles.
REQ-026 Scenario: beq $1,$1,-1 at address 0x10 -> `pc` returns to 0x10 each 3 cycles; `instret` increments each loop.
REQ-027 Scenario: opcode 0x3F fetched at address 0x8 -> `halted`=1, `state`=5, `pc`=0xC, no further `mem_req`, `instret` unchanged; `rst` then gives `pc`=RESET_PC and `halted`=0.
REQ-028 Scenario: NREG=8, addi $9,$0,1 then add $2,$9,$0 -> R2=0; addi $0,$0,3 leaves R0=0.
REQ-029 Scenario: `rst` asserted during a stalled sw MEM state -> memory observes no completed write; next fetch is at RESET_PC.
